// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC core: opcodes, ALU mm codes, FSM states
// and status-register bit positions.
package sisc_pkg;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ALU_RR = 4'd1;
    localparam logic [3:0] OP_ALU_RI = 4'd2;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_HLT    = 4'd15;

    localparam logic [3:0] MM_ADD = 4'd0;
    localparam logic [3:0] MM_SUB = 4'd1;
    localparam logic [3:0] MM_AND = 4'd2;
    localparam logic [3:0] MM_OR  = 4'd3;
    localparam logic [3:0] MM_XOR = 4'd4;
    localparam logic [3:0] MM_NOT = 4'd5;
    localparam logic [3:0] MM_SHL = 4'd6;
    localparam logic [3:0] MM_SHR = 4'd7;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WBACK,
        ST_HALT
    } state_t;

    localparam int STAT_C = 3;
    localparam int STAT_N = 2;
    localparam int STAT_V = 1;
    localparam int STAT_Z = 0;

endpackage

// File: rtl/sisc_if.sv
// Instruction-memory fetch port: request/address from the core, data/valid
// back from memory.
interface sisc_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            imem_valid;

    modport master (output imem_req, imem_addr, input imem_data, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_data, imem_valid);
endinterface

// File: rtl/sisc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// R0 hard-wired to zero, asynchronous active-low clear.
module sisc_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] regs [NREGS];

    // Write port; R0 is never stored so it always reads back as zero
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/sisc_core.sv
// Multi-cycle SISC core: fetch/decode/execute/writeback sequencer with PC,
// branches, halt, ALU and status register. Define SISC_SHIFT_EN to build
// the SHL/SHR shifter for mm codes 6/7; otherwise those codes act as NOP.
module sisc_core
    import sisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int PC_W   = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_f,
    sisc_if.master            imem,
    output logic              halt,
    output logic [3:0]        stat,
    output logic              wb_we,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q, b_q;
    logic [3:0]        flags_q;
    logic              stat_ld;

    logic [3:0]        op, mm;
    logic [AW-1:0]     rd, rs, rt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_x;
    logic [PC_W-1:0]   pc_imm;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              is_alu, br_take;

    assign op     = ir[31:28];
    assign mm     = ir[27:24];
    assign rd     = ir[20 +: AW];
    assign rs     = ir[16 +: AW];
    assign rt     = ir[12 +: AW];
    assign imm    = ir[15:0];
    assign imm_x  = DATA_W'($signed(imm));
    // PC_W never exceeds 16, so truncating imm equals sign-extend-then-wrap
    assign pc_imm = imm[PC_W-1:0];
    assign is_alu  = (op == OP_ALU_RR) || (op == OP_ALU_RI);
    assign br_take = (mm == 4'd0) || ((stat & mm) != 4'd0);
    assign imem.imem_addr = pc;

    sisc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_f   (rst_f),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rdata_a),
        .raddr_b (rt),
        .rdata_b (rdata_b)
    );

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, alu_ok;
    logic [3:0]        alu_flags;
`ifdef SISC_SHIFT_EN
    logic [6:0]        shamt;
    assign shamt = {1'b0, b_q[5:0]};
`endif

    // ALU on the operands latched in DECODE
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ok  = 1'b1;
        case (mm)
            MM_ADD: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            MM_SUB: begin
                sum     = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            MM_AND: alu_res = a_q & b_q;
            MM_OR:  alu_res = a_q | b_q;
            MM_XOR: alu_res = a_q ^ b_q;
            MM_NOT: alu_res = ~a_q;
`ifdef SISC_SHIFT_EN
            MM_SHL: alu_res = (shamt >= 7'(DATA_W)) ? '0 : (a_q << shamt);
            MM_SHR: alu_res = (shamt >= 7'(DATA_W)) ? '0 : (a_q >> shamt);
`endif
            default: alu_ok = 1'b0;
        endcase
        alu_flags = '0;
        alu_flags[STAT_C] = alu_c;
        alu_flags[STAT_N] = alu_res[DATA_W-1];
        alu_flags[STAT_V] = alu_v;
        alu_flags[STAT_Z] = (alu_res == '0);
    end

    // Instruction sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state         <= ST_START;
            pc            <= '0;
            ir            <= '0;
            a_q           <= '0;
            b_q           <= '0;
            flags_q       <= '0;
            stat_ld       <= 1'b0;
            stat          <= '0;
            halt          <= 1'b0;
            imem.imem_req <= 1'b0;
            wb_we         <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
        end else begin
            case (state)
                ST_START: begin
                    imem.imem_req <= 1'b1;
                    state         <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        ir            <= imem.imem_data;
                        pc            <= pc + 1'b1;
                        imem.imem_req <= 1'b0;
                        state         <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_q   <= rdata_a;
                    b_q   <= (op == OP_ALU_RI) ? imm_x : rdata_b;
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    stat_ld <= 1'b0;
                    if (op == OP_HLT) begin
                        halt  <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        state <= ST_WBACK;
                        if (is_alu && alu_ok) begin
                            wb_we   <= 1'b1;
                            wb_addr <= rd;
                            wb_data <= alu_res;
                            flags_q <= alu_flags;
                            stat_ld <= 1'b1;
                        end
                        if (op == OP_BRA && br_take) pc <= pc_imm;
                        if (op == OP_BRR && br_take) pc <= pc + pc_imm;
                    end
                end
                ST_WBACK: begin
                    wb_we <= 1'b0;
                    if (stat_ld) stat <= flags_q;
                    imem.imem_req <= 1'b1;
                    state         <= ST_FETCH;
                end
                ST_HALT: begin
                    halt          <= 1'b1;
                    imem.imem_req <= 1'b0;
                end
                default: state <= ST_START;
            endcase
        end
    end
endmodule

// File: tb/tb_sisc_core.sv
// Directed bench for sisc_core: runs a small program from a bench-owned
// instruction memory and checks fetch, writeback, status, branch, halt and
// reset behaviour against hand-computed values. Honours SISC_SHIFT_EN.
module tb_sisc_core;
    logic        clk = 1'b0;
    logic        rst_f;
    logic        mem_ready;
    logic [31:0] mem [256];
    logic        halt;
    logic [3:0]  stat;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    sisc_if #(.PC_W(16)) imem_bus ();

    assign imem_bus.imem_data  = mem[imem_bus.imem_addr[7:0]];
    assign imem_bus.imem_valid = mem_ready;

    sisc_core #(.DATA_W(32), .NREGS(16), .PC_W(16)) dut (
        .clk     (clk),
        .rst_f   (rst_f),
        .imem    (imem_bus),
        .halt    (halt),
        .stat    (stat),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] mm,
                                        input logic [3:0] rd, input logic [3:0] rs,
                                        input logic [15:0] imm);
        return {op, mm, rd, rs, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // From a WBACK (or reset release) run one instruction up to its WBACK cycle
    task automatic run_instr(input string tag, input int stall, input logic [15:0] exp_pc,
                             input logic [3:0] exp_stat, input logic exp_we,
                             input logic [3:0] exp_wa, input logic [31:0] exp_wd);
        mem_ready = (stall == 0);
        tick(1);
        check({tag, ".req"}, imem_bus.imem_req, 1);
        check({tag, ".addr"}, imem_bus.imem_addr, exp_pc);
        check({tag, ".stat"}, stat, exp_stat);
        for (int i = 0; i < stall; i++) begin
            tick(1);
            check({tag, ".wreq"}, imem_bus.imem_req, 1);
            check({tag, ".waddr"}, imem_bus.imem_addr, exp_pc);
        end
        mem_ready = 1'b1;
        tick(3);
        check({tag, ".we"}, wb_we, exp_we);
        if (exp_we) begin
            check({tag, ".wa"}, wb_addr, exp_wa);
            check({tag, ".wd"}, wb_data, exp_wd);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"}, imem_bus.imem_req, 0);
        check({tag, ".addr"}, imem_bus.imem_addr, 0);
        check({tag, ".halt"}, halt, 0);
        check({tag, ".stat"}, stat, 0);
        check({tag, ".we"}, wb_we, 0);
        check({tag, ".wa"}, wb_addr, 0);
        check({tag, ".wd"}, wb_data, 0);
    endtask

    logic [31:0] dbl;
    logic        sh_en;
    logic [3:0]  stat_pre_hlt;

    initial begin
`ifdef SISC_SHIFT_EN
        sh_en        = 1'b1;
        stat_pre_hlt = 4'b0001;
`else
        sh_en        = 1'b0;
        stat_pre_hlt = 4'b0100;
`endif
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h00] = enc(4'd2, 4'd0, 4'd1, 4'd0, 16'h0005);   // ADD R1,R0,#5
        mem[8'h01] = enc(4'd4, 4'd0, 4'd0, 4'd0, 16'h0040);   // BRA always 0x40
        mem[8'h40] = enc(4'd2, 4'd0, 4'd7, 4'd0, 16'h8000);   // ADD R7,R0,#-32768
        for (int k = 1; k <= 16; k++)
            mem[8'h40 + k] = enc(4'd1, 4'd0, 4'd7, 4'd7, 16'h7000); // ADD R7,R7,R7
        mem[8'h51] = enc(4'd1, 4'd5, 4'd1, 4'd7, 16'h0000);   // NOT R1,R7
        mem[8'h52] = enc(4'd2, 4'd0, 4'd2, 4'd1, 16'h0001);   // ADD R2,R1,#1
        mem[8'h53] = enc(4'd1, 4'd1, 4'd3, 4'd2, 16'h2000);   // SUB R3,R2,R2
        mem[8'h54] = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'h0020);   // BRA Z 0x20
        mem[8'h20] = enc(4'd2, 4'd0, 4'd8, 4'd0, 16'h0001);   // ADD R8,R0,#1
        mem[8'h21] = enc(4'd2, 4'd1, 4'd4, 4'd0, 16'h0003);   // SUB R4,R0,#3
        mem[8'h22] = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'h0060);   // BRA Z 0x60
        mem[8'h23] = enc(4'd4, 4'd0, 4'd0, 4'd0, 16'h0005);   // BRA always 5
        mem[8'h05] = enc(4'd5, 4'd0, 4'd0, 4'd0, 16'hFFFF);   // BRR always -1
        mem[8'h06] = enc(4'd2, 4'd6, 4'd9, 4'd8, 16'd40);     // SHL R9,R8,#40
        mem[8'h07] = enc(4'd15, 4'd0, 4'd0, 4'd0, 16'h0000);  // HLT

        rst_f     = 1'b0;
        mem_ready = 1'b1;
        tick(2);
        check_reset_outputs("rst");
        @(negedge clk) rst_f = 1'b1;

        run_instr("add_imm", 0, 16'h0000, 4'b0000, 1, 4'd1, 32'h5);
        check("add_imm.pc1", imem_bus.imem_addr, 16'h0001);
        run_instr("bra_far", 0, 16'h0001, 4'b0000, 0, 4'd0, 32'h0);
        run_instr("seed", 0, 16'h0040, 4'b0000, 1, 4'd7, 32'hFFFF8000);
        for (int k = 1; k <= 16; k++) begin
            dbl = 32'hFFFF8000 << k;
            run_instr("dbl", 0, 16'(16'h40 + k), (k == 1) ? 4'b0100 : 4'b1100, 1, 4'd7, dbl);
        end
        run_instr("not", 0, 16'h0051, 4'b1100, 1, 4'd1, 32'h7FFFFFFF);
        run_instr("add_ovf", 0, 16'h0052, 4'b0000, 1, 4'd2, 32'h80000000);
        run_instr("sub_self", 0, 16'h0053, 4'b0110, 1, 4'd3, 32'h0);
        run_instr("bra_z", 0, 16'h0054, 4'b1001, 0, 4'd0, 32'h0);
        run_instr("stall", 3, 16'h0020, 4'b1001, 1, 4'd8, 32'h1);
        run_instr("sub_imm", 0, 16'h0021, 4'b0000, 1, 4'd4, 32'hFFFFFFFD);
        run_instr("bra_nz", 0, 16'h0022, 4'b0100, 0, 4'd0, 32'h0);
        run_instr("bra_5", 0, 16'h0023, 4'b0100, 0, 4'd0, 32'h0);
        run_instr("brr", 0, 16'h0005, 4'b0100, 0, 4'd0, 32'h0);
        mem[8'h05] = enc(4'd2, 4'd6, 4'd2, 4'd8, 16'd31);     // SHL R2,R8,#31
        run_instr("shl31", 0, 16'h0005, 4'b0100, sh_en, 4'd2, 32'h80000000);
        run_instr("shl40", 0, 16'h0006, 4'b0100, sh_en, 4'd9, 32'h0);

        mem_ready = 1'b1;
        tick(1);
        check("hlt.addr", imem_bus.imem_addr, 16'h0007);
        check("hlt.stat", stat, stat_pre_hlt);
        tick(3);
        check("hlt.halt", halt, 1);
        check("hlt.req", imem_bus.imem_req, 0);
        tick(10);
        check("hlt.halt_hold", halt, 1);
        check("hlt.req_hold", imem_bus.imem_req, 0);
        check("hlt.we_hold", wb_we, 0);

        rst_f = 1'b0;
        #1;
        check_reset_outputs("rst_hlt");
        @(negedge clk) rst_f = 1'b1;
        run_instr("re_add", 0, 16'h0000, 4'b0000, 1, 4'd1, 32'h5);
        rst_f = 1'b0;
        #1;
        check_reset_outputs("rst_wb");
        mem[8'h00] = enc(4'd2, 4'd0, 4'd2, 4'd1, 16'h0000);   // ADD R2,R1,#0
        tick(2);
        @(negedge clk) rst_f = 1'b1;
        run_instr("restart", 0, 16'h0000, 4'b0000, 1, 4'd2, 32'h0);
        run_instr("re_bra", 0, 16'h0001, 4'b0001, 0, 4'd0, 32'h0);
        run_instr("re_seed", 0, 16'h0040, 4'b0001, 1, 4'd7, 32'hFFFF8000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
